// File: rtl/alu_issue.sv
// Execute-stage sequencer for the 8-bit ALU: one instruction in flight, done pulses 3 cycles after the handshake.
// Throughput is one instruction per 4 cycles; in_ready is high only in IDLE, so the producer stalls otherwise.
module alu_issue #(
   parameter int          REG_COUNT = 8,
   parameter int          REG_IDX_W = 3,
   parameter int          DATA_W    = 8,
   parameter logic [7:0]  OP_NOP    = 8'h00
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [7:0]           in_opcode,
   input  logic [REG_IDX_W-1:0] in_rd,
   input  logic [REG_IDX_W-1:0] in_rs0,
   input  logic [REG_IDX_W-1:0] in_rs1,
   input  logic                 in_imm_en,
   input  logic [DATA_W-1:0]    in_imm,
   output logic [7:0]           alu_opcode,
   output logic [DATA_W-1:0]    alu_operand_0,
   output logic [DATA_W-1:0]    alu_operand_1,
   input  logic [DATA_W-1:0]    alu_result,
   output logic                 done,
   output logic                 done_wr,
   output logic [REG_IDX_W-1:0] done_rd,
   output logic [DATA_W-1:0]    done_value,
   input  logic [REG_IDX_W-1:0] dbg_idx,
   output logic [DATA_W-1:0]    dbg_data
);

   typedef enum logic [1:0] {IDLE, OPERAND, EXEC, WB} state_t;

   typedef struct packed {
      logic [7:0]           opcode;
      logic [REG_IDX_W-1:0] rd;
      logic [REG_IDX_W-1:0] rs0;
      logic [REG_IDX_W-1:0] rs1;
      logic                 imm_en;
      logic [DATA_W-1:0]    imm;
   } instr_t;

   state_t              state, state_nxt;
   instr_t              instr;
   logic [DATA_W-1:0]   result_q;
   logic [DATA_W-1:0]   rf [REG_COUNT];
   logic                wr_en;

   // r0 is never written outside reset, but reads are forced to zero regardless.
   function automatic logic [DATA_W-1:0] rf_read(input logic [REG_IDX_W-1:0] idx);
      return (idx == '0) ? '0 : rf[idx];
   endfunction

   assign wr_en    = (state == WB) && (instr.opcode != OP_NOP) && (instr.rd != '0);
   assign dbg_data = rf_read(dbg_idx);

   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      done       = 1'b0;
      done_wr    = 1'b0;
      done_rd    = '0;
      done_value = '0;
      case (state)
         IDLE: begin
            in_ready = rst_n;
            if (in_valid) state_nxt = OPERAND;
         end
         OPERAND: state_nxt = EXEC;
         EXEC:    state_nxt = WB;
         WB: begin
            done       = 1'b1;
            done_wr    = wr_en;
            done_rd    = instr.rd;
            done_value = result_q;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         instr         <= '0;
         result_q      <= '0;
         alu_opcode    <= '0;
         alu_operand_0 <= '0;
         alu_operand_1 <= '0;
         for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  instr <= '{opcode: in_opcode, rd: in_rd, rs0: in_rs0, rs1: in_rs1,
                             imm_en: in_imm_en, imm: in_imm};
               end
            end
            OPERAND: begin
               alu_opcode    <= instr.opcode;
               alu_operand_0 <= rf_read(instr.rs0);
               alu_operand_1 <= instr.imm_en ? instr.imm : rf_read(instr.rs1);
            end
            EXEC: result_q <= alu_result;
            WB: begin
               alu_opcode    <= '0;
               alu_operand_0 <= '0;
               alu_operand_1 <= '0;
               if (wr_en) rf[instr.rd] <= result_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboarded bench for alu_issue with a behavioural ALU on the far side of its interface.
module tb_alu_issue;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready;
   logic [7:0] in_opcode;
   logic [2:0] in_rd, in_rs0, in_rs1;
   logic       in_imm_en;
   logic [7:0] in_imm;
   logic [7:0] alu_opcode, alu_operand_0, alu_operand_1, alu_result;
   logic       done, done_wr;
   logic [2:0] done_rd;
   logic [7:0] done_value;
   logic [2:0] dbg_idx;
   logic [7:0] dbg_data;

   typedef struct packed {
      logic       wr;
      logic [2:0] rd;
      logic [7:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   done_cyc[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   alu_issue dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
      .in_rd(in_rd), .in_rs0(in_rs0), .in_rs1(in_rs1),
      .in_imm_en(in_imm_en), .in_imm(in_imm),
      .alu_opcode(alu_opcode), .alu_operand_0(alu_operand_0),
      .alu_operand_1(alu_operand_1), .alu_result(alu_result),
      .done(done), .done_wr(done_wr), .done_rd(done_rd), .done_value(done_value),
      .dbg_idx(dbg_idx), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      case (alu_opcode)
         8'h01:   alu_result = alu_operand_0 + alu_operand_1;
         8'h02:   alu_result = alu_operand_0 - alu_operand_1;
         8'h03:   alu_result = alu_operand_0 | alu_operand_1;
         8'h04:   alu_result = alu_operand_0 & alu_operand_1;
         8'h05:   alu_result = alu_operand_0 ^ alu_operand_1;
         default: alu_result = 8'h00;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("unexpected_done", {19'd0, done_wr, done_rd, done_value}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("done_record", {19'd0, done_wr, done_rd, done_value}, {19'd0, e.wr, e.rd, e.val});
         end
      end
   end

   task automatic wait_ready(input string name);
      int n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) check({name, "_ready_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic issue(input logic [7:0] op, input logic [2:0] rd, input logic [2:0] rs0,
                        input logic [2:0] rs1, input logic imm_en, input logic [7:0] imm,
                        input bit hold, input bit push, input logic exp_wr, input logic [7:0] exp_val);
      exp_t e;
      @(negedge clk);
      in_opcode = op; in_rd = rd; in_rs0 = rs0; in_rs1 = rs1;
      in_imm_en = imm_en; in_imm = imm; in_valid = 1'b1;
      wait_ready("issue");
      e.wr = exp_wr; e.rd = rd; e.val = exp_val;
      if (push) exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      @(negedge clk);
      wait_ready("idle");
   endtask

   task automatic dbg_chk(input string name, input logic [2:0] idx, input logic [7:0] exp);
      dbg_idx = idx;
      #1;
      check(name, {24'd0, dbg_data}, {24'd0, exp});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_rd = '0; in_rs0 = '0;
      in_rs1 = '0; in_imm_en = 1'b0; in_imm = '0; dbg_idx = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_alu_opcode", {24'd0, alu_opcode}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 8; i++) dbg_chk("rst_dbg", 3'(i), 8'h00);

      // ADD r1 <- r0 + 0x05, with cycle-exact latency checks
      issue(8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'h05);
      @(negedge clk);
      check("operand_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      check("exec_alu_opcode", {24'd0, alu_opcode}, 32'h01);
      check("exec_operand_0", {24'd0, alu_operand_0}, 32'h00);
      check("exec_operand_1", {24'd0, alu_operand_1}, 32'h05);
      check("exec_done_low", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("wb_done", {31'd0, done}, 32'd1);
      @(negedge clk);
      check("idle_in_ready", {31'd0, in_ready}, 32'd1);
      check("wb_alu_cleared", {24'd0, alu_opcode}, 32'h00);
      dbg_chk("add_r1", 3'd1, 8'h05);

      // Wrap-around through the ALU
      issue(8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF);
      issue(8'h01, 3'd2, 3'd0, 3'd0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01);
      issue(8'h01, 3'd3, 3'd1, 3'd2, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b1, 8'h00);
      issue(8'h01, 3'd4, 3'd0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
      issue(8'h02, 3'd5, 3'd4, 3'd2, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 8'hFF);
      wait_idle();
      dbg_chk("add_wrap_r3", 3'd3, 8'h00);
      dbg_chk("sub_wrap_r5", 3'd5, 8'hFF);

      // Back-to-back with in_valid held high and a RAW dependency
      issue(8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b1, 8'hF0);
      wait_idle();
      n0 = done_cyc.size();
      issue(8'h05, 3'd2, 3'd1, 3'd0, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b1, 8'hFF);
      issue(8'h03, 3'd3, 3'd2, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF);
      wait_idle();
      if (done_cyc.size() >= n0 + 2)
         check("b2b_interval", 32'(done_cyc[n0+1] - done_cyc[n0]), 32'd4);
      else
         check("b2b_done_count", 32'(done_cyc.size() - n0), 32'd2);
      dbg_chk("or_r3", 3'd3, 8'hFF);

      // No writeback: NOP and writes to r0
      issue(8'h00, 3'd3, 3'd1, 3'd0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 8'h00);
      issue(8'h01, 3'd0, 3'd0, 3'd0, 1'b1, 8'h7A, 1'b0, 1'b1, 1'b0, 8'h7A);
      wait_idle();
      dbg_chk("nop_r3", 3'd3, 8'hFF);
      dbg_chk("r0_zero", 3'd0, 8'h00);

      // Unknown opcode writes the ALU's zero result
      issue(8'h01, 3'd6, 3'd0, 3'd0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11);
      issue(8'h09, 3'd6, 3'd1, 3'd0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h00);
      wait_idle();
      dbg_chk("unknown_r6", 3'd6, 8'h00);

      // Reset during EXEC aborts the instruction and clears the register file
      issue(8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("abort_rel_ready", {31'd0, in_ready}, 32'd1);
      dbg_chk("abort_r1", 3'd1, 8'h00);
      dbg_chk("abort_r5", 3'd5, 8'h00);
      repeat (6) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
